// File: rtl/meter_pkg.sv
// Shared constants, request indices and BCD converter state encoding
// for the parking-meter time register controller.
package meter_pkg;

    localparam int unsigned ADD10     = 10;
    localparam int unsigned ADD180    = 180;
    localparam int unsigned ADD200    = 200;
    localparam int unsigned ADD550    = 550;
    localparam int unsigned PRESET_LO = 10;
    localparam int unsigned PRESET_HI = 205;

    // Request indices; a higher index means a higher arbitration priority.
    localparam int unsigned REQ_ADD10    = 0;
    localparam int unsigned REQ_ADD180   = 1;
    localparam int unsigned REQ_ADD200   = 2;
    localparam int unsigned REQ_ADD550   = 3;
    localparam int unsigned REQ_TICK     = 4;
    localparam int unsigned REQ_RESET10  = 5;
    localparam int unsigned REQ_RESET205 = 6;
    localparam int unsigned NREQ         = 7;

    typedef enum logic [1:0] {
        BCD_IDLE,
        BCD_LOAD,
        BCD_SHIFT,
        BCD_DONE
    } bcd_state_e;

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        for (int unsigned k = 0; k < 4; k++) begin
            if (r[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = r[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: CW-bit binary to 4-digit BCD.
// One iteration per clock; bcd_o is only written in DONE, so it never
// exposes a partial result.
module bin2bcd_seq
    import meter_pkg::*;
#(
    parameter int unsigned CW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [CW-1:0] bin_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [15:0]   bcd_o
);

    localparam int unsigned IW = $clog2(CW + 1);

    bcd_state_e    state_q, state_d;
    logic [CW-1:0] bin_q, bin_d;
    logic [15:0]   work_q, work_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [IW-1:0] iter_q, iter_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BCD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BCD_IDLE:  if (start_i) state_d = BCD_LOAD;
            BCD_LOAD:  state_d = BCD_SHIFT;
            BCD_SHIFT: if (iter_q == IW'(CW - 1)) state_d = BCD_DONE;
            BCD_DONE:  state_d = BCD_IDLE;
            default:   state_d = BCD_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        busy_o = (state_q != BCD_IDLE);
        done_o = (state_q == BCD_DONE);
    end

    // Datapath next values: snapshot, initialise, iterate, publish
    always_comb begin
        bin_d  = bin_q;
        work_d = work_q;
        iter_d = iter_q;
        bcd_d  = bcd_q;
        unique case (state_q)
            BCD_IDLE: if (start_i) bin_d = bin_i;
            BCD_LOAD: begin
                work_d = '0;
                iter_d = '0;
            end
            BCD_SHIFT: begin
                {work_d, bin_d} = {bcd_adjust(work_q), bin_q} << 1;
                iter_d          = iter_q + IW'(1);
            end
            BCD_DONE: bcd_d = work_q;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            work_q <= '0;
            iter_q <= '0;
            bcd_q  <= '0;
        end else begin
            bin_q  <= bin_d;
            work_q <= work_d;
            iter_q <= iter_d;
            bcd_q  <= bcd_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/meter_ctrl.sv
// Parking-meter time register: fixed-priority arbitration of button adds,
// presets and the 1 Hz tick onto a saturating binary count, plus status
// flags and a background BCD conversion for the display.
module meter_ctrl
    import meter_pkg::*;
#(
    parameter int unsigned CW        = 14,
    parameter int unsigned MAX_COUNT = 9999,
    parameter int unsigned FLASH_TH  = 200
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sec_tick,
    input  logic          add10,
    input  logic          add180,
    input  logic          add200,
    input  logic          add550,
    input  logic          reset10,
    input  logic          reset205,
    output logic [CW-1:0] count,
    output logic [15:0]   bcd,
    output logic          bcd_valid,
    output logic          flash,
    output logic          expired,
    output logic [6:0]    grant,
    output logic          drop_err
);

    logic [NREQ-1:0] req, cand, gnt_d;
    logic [NREQ-1:0] pend_q, pend_d;
    logic [NREQ-1:0] grant_q;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   add_val;
    logic [CW:0]     sum;
    logic            drop_q, drop_d;
    logic            flash_q, flash_d;
    logic            expired_q, expired_d;
    logic            dirty_q, dirty_d;
    logic            bcd_valid_q, bcd_valid_d;
    logic            count_chg, is_preset;
    logic            conv_start, conv_busy, conv_done;
    logic [15:0]     conv_bcd;

    // Gather request inputs into the priority-indexed vector
    always_comb begin
        req                = '0;
        req[REQ_RESET205]  = reset205;
        req[REQ_RESET10]   = reset10;
        req[REQ_TICK]      = sec_tick;
        req[REQ_ADD550]    = add550;
        req[REQ_ADD200]    = add200;
        req[REQ_ADD180]    = add180;
        req[REQ_ADD10]     = add10;
    end

    // Fixed-priority grant over pending and newly raised requests
    always_comb begin
        cand  = pend_q | req;
        gnt_d = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (cand[i]) begin
                gnt_d    = '0;
                gnt_d[i] = 1'b1;
            end
        end
        is_preset = gnt_d[REQ_RESET205] | gnt_d[REQ_RESET10];
    end

    // Apply the granted request to the count (adds saturate at MAX_COUNT)
    always_comb begin
        count_d = count_q;
        add_val = '0;
        sum     = '0;
        if (gnt_d[REQ_RESET205]) begin
            count_d = CW'(PRESET_HI);
        end else if (gnt_d[REQ_RESET10]) begin
            count_d = CW'(PRESET_LO);
        end else if (gnt_d[REQ_TICK]) begin
            count_d = (count_q != '0) ? count_q - CW'(1) : '0;
        end else if (gnt_d != '0) begin
            if (gnt_d[REQ_ADD550]) add_val = CW'(ADD550);
            if (gnt_d[REQ_ADD200]) add_val = CW'(ADD200);
            if (gnt_d[REQ_ADD180]) add_val = CW'(ADD180);
            if (gnt_d[REQ_ADD10])  add_val = CW'(ADD10);
            sum     = {1'b0, count_q} + {1'b0, add_val};
            count_d = (sum > (CW+1)'(MAX_COUNT)) ? CW'(MAX_COUNT) : sum[CW-1:0];
        end
    end

    // Pending bookkeeping; a preset flushes everything and swallows
    // same-edge requests without flagging them as dropped
    always_comb begin
        if (is_preset) begin
            pend_d = '0;
            drop_d = drop_q;
        end else begin
            pend_d = cand & ~gnt_d;
            drop_d = drop_q | (|(req & pend_q & ~gnt_d));
        end
    end

    // Status flags and BCD bookkeeping derived from the next count
    always_comb begin
        count_chg  = (count_d != count_q);
        flash_d    = (count_d < CW'(FLASH_TH));
        expired_d  = (count_d == '0);
        conv_start = dirty_q & ~conv_busy;
        // A change on the snapshot edge must keep dirty set, since the
        // converter captured the old count.
        dirty_d    = count_chg | (dirty_q & ~conv_start);
        bcd_valid_d = bcd_valid_q;
        if (count_chg) begin
            bcd_valid_d = 1'b0;
        end else if (conv_done) begin
            bcd_valid_d = ~dirty_q;
        end
    end

    // Controller registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            pend_q      <= '0;
            grant_q     <= '0;
            drop_q      <= 1'b0;
            flash_q     <= 1'b1;
            expired_q   <= 1'b1;
            dirty_q     <= 1'b0;
            bcd_valid_q <= 1'b1;
        end else begin
            count_q     <= count_d;
            pend_q      <= pend_d;
            grant_q     <= gnt_d;
            drop_q      <= drop_d;
            flash_q     <= flash_d;
            expired_q   <= expired_d;
            dirty_q     <= dirty_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    bin2bcd_seq #(
        .CW(CW)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (conv_start),
        .bin_i   (count_q),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    assign count     = count_q;
    assign bcd       = conv_bcd;
    assign bcd_valid = bcd_valid_q;
    assign flash     = flash_q;
    assign expired   = expired_q;
    assign grant     = grant_q;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_meter_ctrl.sv
// Directed self-checking bench for meter_ctrl.
module tb_meter_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sec_tick, add10, add180, add200, add550, reset10, reset205;
    logic [13:0] count;
    logic [15:0] bcd;
    logic        bcd_valid, flash, expired, drop_err;
    logic [6:0]  grant;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc;

    // Request vectors: {reset205, reset10, tick, add550, add200, add180, add10}
    localparam logic [6:0] R_205  = 7'b1000000;
    localparam logic [6:0] R_10   = 7'b0100000;
    localparam logic [6:0] R_TICK = 7'b0010000;
    localparam logic [6:0] R_550  = 7'b0001000;
    localparam logic [6:0] R_200  = 7'b0000100;
    localparam logic [6:0] R_180  = 7'b0000010;
    localparam logic [6:0] R_A10  = 7'b0000001;

    meter_ctrl #(
        .CW(14),
        .MAX_COUNT(9999),
        .FLASH_TH(200)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sec_tick  (sec_tick),
        .add10     (add10),
        .add180    (add180),
        .add200    (add200),
        .add550    (add550),
        .reset10   (reset10),
        .reset205  (reset205),
        .count     (count),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .flash     (flash),
        .expired   (expired),
        .grant     (grant),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request vector for exactly one rising edge; returns on the next falling edge.
    task automatic pulse(input logic [6:0] r);
        {reset205, reset10, sec_tick, add550, add200, add180, add10} = r;
        @(negedge clk);
        {reset205, reset10, sec_tick, add550, add200, add180, add10} = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        while (!bcd_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (!bcd_valid) check("valid_timeout", 32'(bcd_valid), 32'd1);
    endtask

    task automatic wait_bcd_change(input logic [15:0] old);
        int c;
        c = 0;
        while (bcd === old && c < 60) begin
            @(negedge clk);
            c++;
        end
        if (bcd === old) check("bcd_write_timeout", 32'(bcd), 32'hFFFF_FFFF);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_count"},   32'(count),     32'd0);
        check({pfx, "_bcd"},     32'(bcd),       32'd0);
        check({pfx, "_valid"},   32'(bcd_valid), 32'd1);
        check({pfx, "_flash"},   32'(flash),     32'd1);
        check({pfx, "_expired"}, 32'(expired),   32'd1);
        check({pfx, "_grant"},   32'(grant),     32'd0);
        check({pfx, "_drop"},    32'(drop_err),  32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        {reset205, reset10, sec_tick, add550, add200, add180, add10} = '0;
        idle(2);
        check_reset_values("rst");
        rst_n = 1'b1;
        idle(2);

        // add550 from zero, then full conversion latency
        pulse(R_550);
        check("a550_count", 32'(count), 32'd550);
        check("a550_grant", 32'(grant), 32'(R_550));
        check("a550_flash", 32'(flash), 32'd0);
        check("a550_exp",   32'(expired), 32'd0);
        check("a550_vlow",  32'(bcd_valid), 32'd0);
        wait_valid(cyc);
        check("a550_lat",   32'(cyc), 32'd17);
        check("a550_bcd",   32'(bcd), 32'h0550);
        check("a550_gidle", 32'(grant), 32'd0);

        // simultaneous tick/add200/add10 from 100
        pulse(R_10);
        check("p10_count", 32'(count), 32'd10);
        check("p10_grant", 32'(grant), 32'(R_10));
        for (int i = 0; i < 9; i++) pulse(R_A10);
        check("to100", 32'(count), 32'd100);
        pulse(R_TICK | R_200 | R_A10);
        check("arb1_count", 32'(count), 32'd99);
        check("arb1_grant", 32'(grant), 32'(R_TICK));
        idle(1);
        check("arb2_count", 32'(count), 32'd299);
        check("arb2_grant", 32'(grant), 32'(R_200));
        idle(1);
        check("arb3_count", 32'(count), 32'd309);
        check("arb3_grant", 32'(grant), 32'(R_A10));
        check("arb_drop",   32'(drop_err), 32'd0);
        idle(1);
        check("arb4_grant", 32'(grant), 32'd0);

        // saturation at 9999: 10 + 17*550 + 3*180 = 9900
        pulse(R_10);
        for (int i = 0; i < 17; i++) pulse(R_550);
        for (int i = 0; i < 3; i++) pulse(R_180);
        check("to9900", 32'(count), 32'd9900);
        pulse(R_550);
        check("sat_count", 32'(count), 32'd9999);
        pulse(R_A10);
        check("sat_hold", 32'(count), 32'd9999);
        wait_valid(cyc);
        check("sat_bcd", 32'(bcd), 32'h9999);

        // underflow guard
        pulse(R_10);
        for (int i = 0; i < 9; i++) pulse(R_TICK);
        check("to1", 32'(count), 32'd1);
        check("c1_exp", 32'(expired), 32'd0);
        pulse(R_TICK);
        check("t0_count", 32'(count), 32'd0);
        check("t0_exp",   32'(expired), 32'd1);
        check("t0_flash", 32'(flash), 32'd1);
        pulse(R_TICK);
        check("t00_count", 32'(count), 32'd0);
        check("t00_grant", 32'(grant), 32'(R_TICK));

        // preset flushes a same-edge add180
        pulse(R_200); pulse(R_200);
        for (int i = 0; i < 10; i++) pulse(R_A10);
        check("to500", 32'(count), 32'd500);
        pulse(R_205 | R_180);
        check("p205_count", 32'(count), 32'd205);
        check("p205_grant", 32'(grant), 32'(R_205));
        check("p205_flash", 32'(flash), 32'd0);
        idle(1);
        check("p205_flushed", 32'(count), 32'd205);
        check("p205_gidle",   32'(grant), 32'd0);
        check("p205_drop",    32'(drop_err), 32'd0);
        pulse(R_TICK);
        check("p205_tick", 32'(count), 32'd204);
        check("flash_199", 32'(flash), 32'd0);

        // duplicate request while pending sets sticky drop_err
        pulse(R_TICK | R_A10);
        check("dup1_count", 32'(count), 32'd203);
        check("dup1_drop",  32'(drop_err), 32'd0);
        pulse(R_TICK | R_A10);
        check("dup2_count", 32'(count), 32'd202);
        check("dup2_drop",  32'(drop_err), 32'd1);
        idle(1);
        check("dup3_count", 32'(count), 32'd212);
        check("dup3_grant", 32'(grant), 32'(R_A10));
        idle(1);
        check("dup4_count", 32'(count), 32'd212);
        check("dup_sticky", 32'(drop_err), 32'd1);

        // count change in the middle of a conversion
        pulse(R_10); pulse(R_200);
        for (int i = 0; i < 8; i++) pulse(R_A10);
        wait_valid(cyc);
        check("c290_bcd", 32'(bcd), 32'h0290);
        pulse(R_A10);
        check("c300_count", 32'(count), 32'd300);
        idle(4);
        pulse(R_A10);
        check("c310_count", 32'(count), 32'd310);
        wait_bcd_change(16'h0290);
        check("mid_bcd",   32'(bcd), 32'h0300);
        check("mid_valid", 32'(bcd_valid), 32'd0);
        wait_valid(cyc);
        check("re_bcd",   32'(bcd), 32'h0310);
        check("re_valid", 32'(bcd_valid), 32'd1);

        // asynchronous reset mid-conversion
        pulse(R_550);
        check("pre_rst_count", 32'(count), 32'd860);
        idle(5);
        #2 rst_n = 1'b0;
        #1 check_reset_values("arst");
        @(negedge clk);
        rst_n = 1'b1;
        idle(25);
        check("post_count", 32'(count), 32'd0);
        check("post_valid", 32'(bcd_valid), 32'd1);
        check("post_bcd",   32'(bcd), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/meter_ctrl.md
Name: meter_ctrl

Overview:
- Sequencing and arbitration controller for the parking-meter time register.
- Accepts single-cycle add pulses from the four debounced buttons, the two preset-reset requests and the 1 Hz decrement tick.
- Grants at most one request per clock and applies it to a 14-bit binary remaining-time count.
- Converts the count to 4-digit BCD for the display FSM and derives the flash and expired status.

Parameters:
- CW, 14, count width in bits.
- MAX_COUNT, 9999, saturation ceiling.
- FLASH_TH, 200, flash asserted while count < FLASH_TH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sec_tick  in  1  one-cycle pulse at 1 Hz; decrement request.
- add10  in  1  one-cycle pulse; add 10.
- add180  in  1  one-cycle pulse; add 180.
- add200  in  1  one-cycle pulse; add 200.
- add550  in  1  one-cycle pulse; add 550.
- reset10  in  1  request; load 10.
- reset205  in  1  request; load 205.
- count  out  CW  remaining time, binary.
- bcd  out  16  {thousands, hundreds, tens, units} of the last converted count.
- bcd_valid  out  1  high when bcd equals the current count.
- flash  out  1  count < FLASH_TH (registered).
- expired  out  1  count == 0 (registered).
- grant  out  7  registered one-hot of the request applied this edge; 0 when none.
- drop_err  out  1  sticky; a request was lost.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - count = 0, bcd = 0, bcd_valid = 1.
  - flash = 1, expired = 1.
  - grant = 0, drop_err = 0, all pending flags = 0.
- Candidate set, evaluated each edge: pending[i] OR request input[i].
- Fixed priority, high to low: reset205, reset10, sec_tick, add550, add200, add180, add10.
- On each edge:
  - The highest-priority candidate is granted and applied to count.
  - Its pending flag is cleared.
  - Every other candidate sets its pending flag.
  - Latency from request sampled to count update is 1 edge when the request is top priority; otherwise 1 edge per higher-priority candidate ahead of it.
- Duplicate requests: if a request input is high while its own pending flag is already set and not granted, the request is dropped and drop_err is set. drop_err clears only on rst_n.
- Reset grant (reset205 or reset10):
  - count loads 205 or 10.
  - All other pending flags are cleared, including a pending tick.
  - Any request input high on that same edge is discarded without setting drop_err.
- Tick grant: count = count − 1 when count > 0; when count == 0, count stays 0 and the tick is consumed.
- Add grant: count = min(count + value, MAX_COUNT). The sum is computed in CW+1 bits before saturation.
- Status outputs: flash and expired are registered from the next count value, so they are coincident with count.
- BCD conversion state machine: states IDLE, LOAD, SHIFT, DONE.
  - Any count change sets a dirty flag and drives bcd_valid low on the same edge.
  - IDLE with dirty set → LOAD: snapshot count and clear dirty.
  - SHIFT: 14 double-dabble iterations (add 3 to any BCD digit ≥ 5, then shift).
  - DONE: write bcd; set bcd_valid = 1 only if dirty is still clear; return to IDLE.
  - Total 16 cycles from LOAD to bcd valid.
  - If count changes mid-conversion, the conversion completes, bcd updates, bcd_valid stays low, and a new conversion restarts from IDLE.
  - bcd is never written with partial results.
- rst_n asserted mid-conversion aborts to IDLE with the reset values above.

Decomposition:
- Package meter_pkg holds:
  - ADD10 = 10, ADD180 = 180, ADD200 = 200, ADD550 = 550.
  - PRESET_LO = 10, PRESET_HI = 205.
  - Request index constants, with the fixed priority order encoded as REQ_RESET205 = 6 down to REQ_ADD10 = 0.
  - BCD FSM state encoding.
- One sub-module, bin2bcd_seq: start/busy/done handshake, CW-bit binary in, 16-bit BCD out, sequential double-dabble. The arbiter and count logic stay in meter_ctrl.

Test Plan:
- Reset, then pulse add550 once → count = 550 one edge later; grant[3] pulses; bcd = 0x0550 and bcd_valid = 1 after 16 cycles; flash = 0.
- add10, add200 and sec_tick on the same edge, starting from count = 100:
  - count goes 99 → 299 → 309 on 3 consecutive edges.
  - grant sequence is tick, add200, add10.
  - drop_err = 0.
- Count = 9900, pulse add550 → count = 9999 (saturated); bcd = 0x9999.
- Count = 1, two sec_tick pulses → count 0, then stays 0; expired = 1; flash = 1; no underflow.
- Count = 500 with add180 pending behind reset205 → count = 205; add180 pending cleared; a later tick gives count = 204.
- Start a conversion of 300, pulse add10 at conversion cycle 5:
  - bcd shows 0x0300 with bcd_valid = 0.
  - Conversion restarts; bcd = 0x0310 with bcd_valid = 1.
  - Assert rst_n low mid-conversion → all outputs return to their reset values immediately.
